vid_timing: RTL and testbench
=============================

VID_TIMING -- requirements
Module: vid_timing

Interface
REQ-001 SHALL: parameter CW, default 13, width of every timing field and of the h/v counters.
REQ-002 SHALL: parameter PDW, default 6, width of pixel divider field pcnt.
REQ-003 SHALL: clk  input  1  single clock; every flop is rising-edge.
REQ-004 SHALL: reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 SHALL: selin  input  1  qualifies bus cycle addressed to this block.
REQ-006 SHALL: cmdin  input  3  bus command: 3'b100 write request, 3'b010 read request.
REQ-007 SHALL: addrdatain  input  32  address in command cycle, write data in following cycle.
REQ-008 SHALL: cmdout  output  3  3'b101 write response, 3'b001 read data, else 3'b000.
REQ-009 SHALL: addrdataout  output  32  read data, valid only when cmdout==3'b001, else 0.
REQ-010 SHALL: hsync, hblank, vsync, vblank  output  1 each  registered timing strobes.
REQ-011 SHALL: irq  output  1  level interrupt = STAT.vbf AND CR.irq_en.

Function
REQ-012 SHALL: register map: CR 0x00 {en[3], pcnt[PDW+3:4], hpol[16], vpol[17], irq_en[18]}; H1 0x28 {hsize[2CW-1:CW], hend[CW-1:0]}; H2 0x30 {hsync_start[2CW-1:CW], hsync_end[CW-1:0]}; V1 0x38 {vsize, vend} same packing; V2 0x40 {vsync_start, vsync_end} same packing; STAT 0x58 {vcnt[CW-1+16:16] RO, vbf[0] W1C}.
REQ-013 SHALL: bus FSM states IDLE, WDATA, WRESP, RRESP; IDLE->WDATA on selin&&cmdin==3'b100 (latch address); WDATA->WRESP capturing addrdatain into addressed register; WRESP drives cmdout=3'b101 one cycle ->IDLE.
REQ-014 SHALL: IDLE->RRESP on selin&&cmdin==3'b010; RRESP drives cmdout=3'b001 and register value (unmapped bits 0) one cycle ->IDLE.
REQ-015 SHALL: unmapped addresses: write discarded but still responded; read returns 0.
REQ-016 SHALL: bus commands arriving outside IDLE ignored.
REQ-017 SHALL: H1/H2/V1/V2 writes go to shadow copies; active copies load from shadow when en rises and at each frame end (hcnt==hend && vcnt==vend on a pixel tick).
REQ-018 SHALL: CR writes take effect the cycle after WDATA (no shadowing).
REQ-019 SHALL: pixel tick pulses every pcnt+1 clocks while en=1; pcnt=0 gives tick every clock.
REQ-020 SHALL: on tick hcnt increments, wrapping to 0 after hend; on wrap vcnt increments, wrapping to 0 after vend; counters CW bits, no overflow beyond end value.
REQ-021 SHALL: hend=0 keeps hcnt at 0 and advances vcnt every tick; vend=0 keeps vcnt at 0.
REQ-022 SHALL: one clk after counter state: hblank=(hcnt>=hsize); hsync=(hsync_start<=hcnt<hsync_end) XOR hpol; vblank=(vcnt>=vsize); vsync=(vsync_start<=vcnt<vsync_end) XOR vpol.
REQ-023 SHALL: sync_start>=sync_end gives sync never active (output = pol).
REQ-024 SHALL: vbf set on the tick where vcnt moves from vsize-1 to vsize at hcnt wrap.
REQ-025 SHALL: simultaneous vbf set and W1C write: set wins.
REQ-026 SHALL: en cleared: divider, hcnt, vcnt held at 0 next cycle; hblank=vblank=1, hsync=hpol, vsync=vpol; vbf retained.

Reset
REQ-027 SHALL: reset=0 at a clock edge clears all registers, shadows, counters, FSM to IDLE, regardless of state mid-operation.
REQ-028 SHALL: outputs during/after reset: cmdout=0, addrdataout=0, hsync=0, vsync=0, hblank=1, vblank=1, irq=0.

Verification
REQ-029 SHALL: write H1=(4<<13)|7 to 0x28 -> cmdout=3'b101 exactly 2 clocks after command cycle; read 0x28 -> addrdataout=0x00008007.
REQ-030 SHALL: H1 hsize=4 hend=7, H2 start=5 end=6, V1 vsize=2 vend=3, CR en=1 pcnt=0 -> hblank high 4 of 8 clocks, hsync 1 of 8, vblank high lines 2-3, frame 32 clocks.
REQ-031 SHALL: same with pcnt=2 -> each hcnt value held 3 clocks, frame 96 clocks.
REQ-032 SHALL: hpol=vpol=1 -> hsync/vsync inverted; irq_en=1 -> irq rises at line 2 start, W1C 0x58 bit0 clears; clear coinciding with set leaves irq=1.
REQ-033 SHALL: write H1 hend=9 mid-frame -> line length stays 8 until frame end, then 10.
REQ-034 SHALL: reset=0 mid-line and mid-write -> next cycle counters 0, cmdout=0, hblank=vblank=1, no write response issued.

Source files
------------

// File: rtl/vid_timing.sv
// Raster timing generator with a small command/response register bus.
// Geometry registers are shadowed and promoted at enable rise and at frame end.
module vid_timing #(
  parameter int CW  = 13,
  parameter int PDW = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [31:0] addrdatain,
  output logic [2:0]  cmdout,
  output logic [31:0] addrdataout,
  output logic        hsync,
  output logic        hblank,
  output logic        vsync,
  output logic        vblank,
  output logic        irq
);
  localparam logic [CW-1:0]  C_ONE  = 1;
  localparam logic [PDW-1:0] D_ONE  = 1;
  localparam logic [31:0]    A_CR   = 32'h00;
  localparam logic [31:0]    A_H1   = 32'h28;
  localparam logic [31:0]    A_H2   = 32'h30;
  localparam logic [31:0]    A_V1   = 32'h38;
  localparam logic [31:0]    A_V2   = 32'h40;
  localparam logic [31:0]    A_STAT = 32'h58;

  // state | meaning
  // IDLE  | waiting for a selected write or read command
  // WDATA | write data on the bus, captured into the addressed register
  // WRESP | write response driven for one cycle
  // RRESP | read data driven for one cycle
  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RRESP} bus_state_e;
  bus_state_e state_q, state_d;

  logic [31:0]    addr_q, addr_d, rd_data;
  logic           wr_stb, wr_cr, wr_h1, wr_h2, wr_v1, wr_v2, wr_stat;
  logic           cr_en_q, cr_hpol_q, cr_vpol_q, cr_irq_en_q;
  logic [PDW-1:0] cr_pcnt_q, div_q, div_d;
  logic [CW-1:0]  sh_hsize_q, sh_hend_q, sh_hss_q, sh_hse_q;
  logic [CW-1:0]  sh_vsize_q, sh_vend_q, sh_vss_q, sh_vse_q;
  logic [CW-1:0]  hsize_q, hend_q, hss_q, hse_q, vsize_q, vend_q, vss_q, vse_q;
  logic [CW-1:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic           vbf_q, vbf_d, vbf_set;
  logic           hsync_q, hblank_q, vsync_q, vblank_q;
  logic           tick, hwrap, vwrap, en_rise, load_act;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_stb      = 1'b0;
    cmdout      = 3'b000;
    addrdataout = '0;
    case (state_q)
      IDLE: begin
        if (selin && cmdin == 3'b100) begin
          addr_d  = addrdatain;
          state_d = WDATA;
        end else if (selin && cmdin == 3'b010) begin
          addr_d  = addrdatain;
          state_d = RRESP;
        end
      end
      WDATA: begin
        wr_stb  = 1'b1;
        state_d = WRESP;
      end
      WRESP: begin
        cmdout  = 3'b101;
        state_d = IDLE;
      end
      RRESP: begin
        cmdout      = 3'b001;
        addrdataout = rd_data;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_cr   = wr_stb && (addr_q == A_CR);
  assign wr_h1   = wr_stb && (addr_q == A_H1);
  assign wr_h2   = wr_stb && (addr_q == A_H2);
  assign wr_v1   = wr_stb && (addr_q == A_V1);
  assign wr_v2   = wr_stb && (addr_q == A_V2);
  assign wr_stat = wr_stb && (addr_q == A_STAT);
  assign en_rise = wr_cr && addrdatain[3] && !cr_en_q;

  always_comb begin
    rd_data = '0;
    if (addr_q == A_CR) begin
      rd_data[3]       = cr_en_q;
      rd_data[PDW+3:4] = cr_pcnt_q;
      rd_data[16]      = cr_hpol_q;
      rd_data[17]      = cr_vpol_q;
      rd_data[18]      = cr_irq_en_q;
    end
    if (addr_q == A_H1) rd_data[2*CW-1:0] = {sh_hsize_q, sh_hend_q};
    if (addr_q == A_H2) rd_data[2*CW-1:0] = {sh_hss_q, sh_hse_q};
    if (addr_q == A_V1) rd_data[2*CW-1:0] = {sh_vsize_q, sh_vend_q};
    if (addr_q == A_V2) rd_data[2*CW-1:0] = {sh_vss_q, sh_vse_q};
    if (addr_q == A_STAT) begin
      rd_data[CW+15:16] = vcnt_q;
      rd_data[0]        = vbf_q;
    end
  end

  // The divider counts down from pcnt; a tick fires on its zero terminal count.
  always_comb begin
    tick    = cr_en_q && (div_q == '0);
    hwrap   = tick && (hcnt_q >= hend_q);
    vwrap   = vcnt_q >= vend_q;
    div_d   = '0;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    vbf_set = 1'b0;
    if (!cr_en_q) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else begin
      div_d = tick ? cr_pcnt_q : div_q - D_ONE;
      if (hwrap) begin
        hcnt_d  = '0;
        vcnt_d  = vwrap ? '0 : vcnt_q + C_ONE;
        vbf_set = !vwrap && ((vcnt_q + C_ONE) == vsize_q);
      end else if (tick) begin
        hcnt_d = hcnt_q + C_ONE;
      end
    end
    load_act = en_rise || (hwrap && vwrap);
    vbf_d    = vbf_set || (vbf_q && !(wr_stat && addrdatain[0]));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cr_en_q     <= 1'b0;
      cr_hpol_q   <= 1'b0;
      cr_vpol_q   <= 1'b0;
      cr_irq_en_q <= 1'b0;
      cr_pcnt_q   <= '0;
      sh_hsize_q  <= '0;
      sh_hend_q   <= '0;
      sh_hss_q    <= '0;
      sh_hse_q    <= '0;
      sh_vsize_q  <= '0;
      sh_vend_q   <= '0;
      sh_vss_q    <= '0;
      sh_vse_q    <= '0;
      hsize_q     <= '0;
      hend_q      <= '0;
      hss_q       <= '0;
      hse_q       <= '0;
      vsize_q     <= '0;
      vend_q      <= '0;
      vss_q       <= '0;
      vse_q       <= '0;
      div_q       <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      vbf_q       <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblank_q    <= 1'b1;
      vblank_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (wr_cr) begin
        cr_en_q     <= addrdatain[3];
        cr_pcnt_q   <= addrdatain[PDW+3:4];
        cr_hpol_q   <= addrdatain[16];
        cr_vpol_q   <= addrdatain[17];
        cr_irq_en_q <= addrdatain[18];
      end
      if (wr_h1) {sh_hsize_q, sh_hend_q} <= addrdatain[2*CW-1:0];
      if (wr_h2) {sh_hss_q, sh_hse_q}    <= addrdatain[2*CW-1:0];
      if (wr_v1) {sh_vsize_q, sh_vend_q} <= addrdatain[2*CW-1:0];
      if (wr_v2) {sh_vss_q, sh_vse_q}    <= addrdatain[2*CW-1:0];
      if (load_act) begin
        hsize_q <= sh_hsize_q;
        hend_q  <= sh_hend_q;
        hss_q   <= sh_hss_q;
        hse_q   <= sh_hse_q;
        vsize_q <= sh_vsize_q;
        vend_q  <= sh_vend_q;
        vss_q   <= sh_vss_q;
        vse_q   <= sh_vse_q;
      end
      div_q    <= div_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      vbf_q    <= vbf_d;
      hblank_q <= !cr_en_q || (hcnt_q >= hsize_q);
      vblank_q <= !cr_en_q || (vcnt_q >= vsize_q);
      hsync_q  <= (cr_en_q && (hcnt_q >= hss_q) && (hcnt_q < hse_q)) ^ cr_hpol_q;
      vsync_q  <= (cr_en_q && (vcnt_q >= vss_q) && (vcnt_q < vse_q)) ^ cr_vpol_q;
    end
  end

  assign hsync  = hsync_q;
  assign hblank = hblank_q;
  assign vsync  = vsync_q;
  assign vblank = vblank_q;
  assign irq    = vbf_q && cr_irq_en_q;
endmodule

// File: tb/tb_vid_timing.sv
// Bench for vid_timing: register vector table, arithmetic raster model with
// randomized geometry, and directed sequences for irq, shadowing and reset.
module tb_vid_timing;
  localparam int CW = 13;
  localparam int PDW = 6;
  localparam logic [31:0] A_CR = 32'h00, A_H1 = 32'h28, A_H2 = 32'h30;
  localparam logic [31:0] A_V1 = 32'h38, A_V2 = 32'h40, A_STAT = 32'h58;

  logic        clk = 1'b0, reset = 1'b0, selin = 1'b0;
  logic [2:0]  cmdin = 3'b000;
  logic [31:0] addrdatain = '0;
  logic [2:0]  cmdout;
  logic [31:0] addrdataout;
  logic        hsync, hblank, vsync, vblank, irq;
  int total = 0, bad = 0, cyc = 0;

  vid_timing #(.CW(CW), .PDW(PDW)) dut (
    .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin), .addrdatain(addrdatain),
    .cmdout(cmdout), .addrdataout(addrdataout), .hsync(hsync), .hblank(hblank),
    .vsync(vsync), .vblank(vblank), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  logic mon_on = 1'b0, prev_hb = 1'b1;
  int mon_base = 0;
  int falls[$];
  always @(negedge clk) begin
    if (mon_on) begin
      if (prev_hb && !hblank) falls.push_back(cyc - mon_base);
      prev_hb <= hblank;
    end else begin
      prev_hb <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic drv(input logic s, input logic [2:0] c, input logic [31:0] d);
    selin = s; cmdin = c; addrdatain = d;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    drv(1'b1, 3'b100, a); step();
    chk("wr_wdata_cmdout", {29'd0, cmdout}, 32'h0);
    drv(1'b0, 3'b000, d); step();
    chk("wr_resp_cmdout", {29'd0, cmdout}, 32'h5);
    drv(1'b0, 3'b000, '0); step();
    chk("wr_idle_cmdout", {29'd0, cmdout}, 32'h0);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    drv(1'b1, 3'b010, a); step();
    drv(1'b0, 3'b000, '0);
    chk("rd_resp_cmdout", {29'd0, cmdout}, 32'h1);
    d = addrdataout;
    step();
  endtask

  function automatic logic [31:0] pk(input int hi, input int lo);
    logic [31:0] r;
    r = '0;
    r[25:13] = hi[12:0];
    r[12:0]  = lo[12:0];
    return r;
  endfunction

  function automatic logic [31:0] cr_word(input int en, input int pc, input int hp, input int vp, input int ie);
    logic [31:0] r;
    r = '0;
    r[3] = en[0]; r[9:4] = pc[5:0]; r[16] = hp[0]; r[17] = vp[0]; r[18] = ie[0];
    return r;
  endfunction

  // Ticks completed before cycle c, where cycle 0 is the first enabled cycle.
  function automatic int pix_at(input int c, input int p);
    return (c <= 0) ? 0 : ((c - 1) / p + 1);
  endfunction

  task automatic setup(input int hs, he, hss, hse, vs, ve, vss, vse);
    bus_write(A_CR, '0);
    bus_write(A_STAT, 32'h1);
    bus_write(A_H1, pk(hs, he));
    bus_write(A_H2, pk(hss, hse));
    bus_write(A_V1, pk(vs, ve));
    bus_write(A_V2, pk(vss, vse));
  endtask

  task automatic run_trial(input int hs, he, hss, hse, vs, ve, vss, vse, pc, hp, vp, ie);
    int p, ncyc, q, h, v;
    logic [31:0] e, g;
    setup(hs, he, hss, hse, vs, ve, vss, vse);
    bus_write(A_CR, cr_word(1, pc, hp, vp, ie));
    p = pc + 1;
    ncyc = 2 * (he + 1) * (ve + 1) * p + 4;
    for (int c = 1; c <= ncyc; c++) begin
      q = pix_at(c - 1, p);
      h = q % (he + 1);
      v = (q / (he + 1)) % (ve + 1);
      e = '0;
      e[4] = ((h >= hss) && (h < hse)) ^ hp[0];
      e[3] = (h >= hs);
      e[2] = ((v >= vss) && (v < vse)) ^ vp[0];
      e[1] = (v >= vs);
      e[0] = ie[0] && (vs >= 1) && (vs <= ve) && (pix_at(c, p) >= vs * (he + 1));
      g = {27'd0, hsync, hblank, vsync, vblank, irq};
      chk("timing", g, e);
      step();
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  initial begin
    vec_t vecs[9];
    int fexp[7];
    logic [31:0] d;
    vecs[0] = '{A_H1, (32'd4 << 13) | 32'd7, 32'h0000_8007};
    vecs[1] = '{A_H2, 32'hFFFF_FFFF, 32'h03FF_FFFF};
    vecs[2] = '{A_V1, 32'h1234_5678, 32'h0234_5678};
    vecs[3] = '{A_V2, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{A_CR, 32'hFFFF_FFF7, 32'h0007_03F0};
    vecs[5] = '{A_CR, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{32'h0000_0029, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{A_STAT, 32'h0000_0001, 32'h0000_0000};
    fexp = '{1, 9, 17, 25, 33, 43, 53};

    repeat (3) step();
    chk("rst_cmdout", {29'd0, cmdout}, 32'h0);
    chk("rst_data", addrdataout, 32'h0);
    chk("rst_strobes", {27'd0, hsync, hblank, vsync, vblank, irq}, 32'b01010);
    reset = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, d);
      chk("reg_readback", d, vecs[i].rexp);
    end
    bus_read(A_H1, d);
    chk("h1_kept", d, 32'h0000_8007);

    run_trial(4, 7, 5, 6, 2, 3, 1, 2, 0, 0, 0, 1);
    run_trial(4, 7, 5, 6, 2, 3, 1, 2, 2, 1, 1, 0);
    run_trial(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    run_trial(1, 0, 1, 0, 2, 3, 2, 2, 0, 1, 0, 1);
    for (int t = 0; t < 6; t++) begin
      int he, ve;
      he = $urandom_range(0, 9);
      ve = $urandom_range(0, 5);
      run_trial($urandom_range(0, he + 2), he, $urandom_range(0, he + 1), $urandom_range(0, he + 1),
                $urandom_range(0, ve + 2), ve, $urandom_range(0, ve + 1), $urandom_range(0, ve + 1),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    // Polarity and interrupt: vbf sets on the tick ending cycle 15.
    setup(4, 7, 5, 6, 2, 3, 3, 3);
    bus_write(A_CR, cr_word(1, 0, 1, 1, 1));
    step();
    chk("hsync_inverted_idle", {31'd0, hsync}, 32'h1);
    chk("vsync_never_active", {31'd0, vsync}, 32'h1);
    repeat (4) step();
    chk("hsync_inverted_active", {31'd0, hsync}, 32'h0);
    repeat (8) step();
    drv(1'b1, 3'b100, A_STAT); step();
    chk("irq_before_line2", {31'd0, irq}, 32'h0);
    drv(1'b0, 3'b000, 32'h1); step();
    chk("irq_set_beats_clear", {31'd0, irq}, 32'h1);
    chk("w1c_resp", {29'd0, cmdout}, 32'h5);
    drv(1'b0, 3'b000, '0); step();
    chk("irq_held", {31'd0, irq}, 32'h1);
    drv(1'b1, 3'b100, A_STAT); step();
    drv(1'b0, 3'b000, 32'h1); step();
    chk("irq_w1c_clear", {31'd0, irq}, 32'h0);
    drv(1'b0, 3'b000, '0); step();

    // Mid-frame hend change takes effect only after the frame wraps.
    setup(4, 7, 5, 6, 2, 3, 1, 2);
    bus_write(A_CR, cr_word(1, 0, 0, 0, 0));
    mon_base = cyc - 1;
    falls.delete();
    mon_on = 1'b1;
    bus_write(A_H1, pk(4, 9));
    while (cyc - mon_base < 60) step();
    mon_on = 1'b0;
    chk("line_count", falls.size(), 32'd7);
    for (int i = 0; i < 7; i++)
      chk("line_start", (i < falls.size()) ? falls[i] : -1, fexp[i]);

    // Reset in the data cycle of a write while the raster is running.
    repeat (3) step();
    drv(1'b1, 3'b100, A_H1); step();
    drv(1'b0, 3'b000, pk(5, 5));
    reset = 1'b0;
    step();
    chk("midrst_cmdout", {29'd0, cmdout}, 32'h0);
    chk("midrst_strobes", {27'd0, hsync, hblank, vsync, vblank, irq}, 32'b01010);
    reset = 1'b1;
    drv(1'b0, 3'b000, '0);
    step();
    chk("midrst_no_resp", {29'd0, cmdout}, 32'h0);
    step();
    chk("midrst_no_resp2", {29'd0, cmdout}, 32'h0);
    bus_read(A_STAT, d);
    chk("midrst_counters", d, 32'h0);
    bus_read(A_H1, d);
    chk("midrst_write_dropped", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
